// File: rtl/vga_pkg.sv
// Shared VGA/framebuffer definitions: screen geometry, pixel RAM address
// width, fill-engine state encoding and the fill command payload.
// No ports (package).
package vga_pkg;

  localparam int unsigned H_RES      = 640;
  localparam int unsigned V_RES      = 480;
  localparam int unsigned ADDR_WIDTH = 19;

  localparam int unsigned CMD_X_W = 10;
  localparam int unsigned CMD_Y_W = 9;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_CLIP = 2'd1,
    ST_FILL = 2'd2,
    ST_DONE = 2'd3
  } fill_state_e;

  typedef struct packed {
    logic [CMD_X_W-1:0] x;
    logic [CMD_Y_W-1:0] y;
    logic [CMD_X_W-1:0] w;
    logic [CMD_Y_W-1:0] h;
    logic               color;
  } fill_cmd_t;

  // Multiply by a constant as a sum of shifted copies; k is elaborated
  // constant at every call site, so this reduces to a fixed adder tree.
  function automatic logic [31:0] shift_add_mul(input logic [31:0] a,
                                                input int unsigned k);
    logic [31:0] acc;
    acc = '0;
    for (int i = 0; i < 32; i++) begin
      if (k[i]) acc = acc + (a << i);
    end
    return acc;
  endfunction

endpackage

// File: rtl/pixel_fill_writer_if.sv
// Fill command handshake plus pixel RAM write port.
// master: command source / RAM side; slave: the fill engine.
//   cmd_valid/cmd_ready, cmd_x/y/w/h/color : command handshake + payload
//   pix_addr/pix_data/pix_wEn               : pixel RAM write port
//   busy/done                               : engine status
interface pixel_fill_writer_if #(
  parameter int unsigned ADDR_WIDTH = vga_pkg::ADDR_WIDTH
);
  logic                  cmd_valid;
  logic                  cmd_ready;
  logic [9:0]            cmd_x;
  logic [8:0]            cmd_y;
  logic [9:0]            cmd_w;
  logic [8:0]            cmd_h;
  logic                  cmd_color;
  logic [ADDR_WIDTH-1:0] pix_addr;
  logic                  pix_data;
  logic                  pix_wEn;
  logic                  busy;
  logic                  done;

  modport master (
    output cmd_valid, cmd_x, cmd_y, cmd_w, cmd_h, cmd_color,
    input  cmd_ready, pix_addr, pix_data, pix_wEn, busy, done
  );

  modport slave (
    input  cmd_valid, cmd_x, cmd_y, cmd_w, cmd_h, cmd_color,
    output cmd_ready, pix_addr, pix_data, pix_wEn, busy, done
  );
endinterface

// File: rtl/pixel_fill_writer.sv
// Rectangle-fill engine for the 1-bit framebuffer: accepts one fill command,
// clips it to the screen, then writes one pixel per clock.
//   clock      : clock shared with the pixel RAM
//   CPU_RESETN : asynchronous active-low reset
//   bus        : command handshake, pixel RAM write port, busy/done status
module pixel_fill_writer
  import vga_pkg::*;
#(
  parameter int unsigned H_RES      = vga_pkg::H_RES,
  parameter int unsigned V_RES      = vga_pkg::V_RES,
  parameter int unsigned ADDR_WIDTH = vga_pkg::ADDR_WIDTH
) (
  input logic                clock,
  input logic                CPU_RESETN,
  pixel_fill_writer_if.slave bus
);

  localparam logic [10:0]           H_LIM = 11'(H_RES);
  localparam logic [9:0]            V_LIM = 10'(V_RES);
  localparam logic [ADDR_WIDTH-1:0] PITCH = ADDR_WIDTH'(H_RES);

  fill_state_e           state_q, state_d;
  fill_cmd_t             cmd_q, cmd_d;
  logic [9:0]            cw_q, cw_d, col_q, col_d;
  logic [8:0]            ch_q, ch_d, row_q, row_d;
  logic [ADDR_WIDTH-1:0] row_base_q, row_base_d, pix_addr_q, pix_addr_d;
  logic                  pix_data_q, pix_data_d, pix_wen_q, pix_wen_d;
  logic                  busy_q, busy_d, done_q, done_d;
  logic                  cmd_ready_q, cmd_ready_d;

  // Clip arithmetic at one extra bit so x+w / y+h style sums cannot wrap.
  logic [10:0] x_ext, w_ext, room_x;
  logic [9:0]  y_ext, h_ext, room_y;
  logic        empty, row_end, last_pix;

  assign x_ext    = {1'b0, cmd_q.x};
  assign w_ext    = {1'b0, cmd_q.w};
  assign y_ext    = {1'b0, cmd_q.y};
  assign h_ext    = {1'b0, cmd_q.h};
  assign room_x   = H_LIM - x_ext;
  assign room_y   = V_LIM - y_ext;
  assign empty    = (x_ext >= H_LIM) || (y_ext >= V_LIM) ||
                    (cmd_q.w == '0) || (cmd_q.h == '0);
  assign row_end  = (col_q == cw_q - 10'd1);
  assign last_pix = row_end && (row_q == ch_q - 9'd1);

  // Next-state and registered-output logic.
  always_comb begin
    state_d    = state_q;
    cmd_d      = cmd_q;
    cw_d       = cw_q;
    ch_d       = ch_q;
    col_d      = col_q;
    row_d      = row_q;
    row_base_d = row_base_q;
    pix_addr_d = pix_addr_q;
    pix_data_d = pix_data_q;

    case (state_q)
      ST_IDLE: begin
        if (bus.cmd_valid && cmd_ready_q) begin
          cmd_d.x     = bus.cmd_x;
          cmd_d.y     = bus.cmd_y;
          cmd_d.w     = bus.cmd_w;
          cmd_d.h     = bus.cmd_h;
          cmd_d.color = bus.cmd_color;
          state_d     = ST_CLIP;
        end
      end
      ST_CLIP: begin
        if (empty) begin
          state_d = ST_DONE;
        end else begin
          cw_d       = 10'((w_ext > room_x) ? room_x : w_ext);
          ch_d       = 9'((h_ext > room_y) ? room_y : h_ext);
          row_base_d = ADDR_WIDTH'(shift_add_mul(32'(cmd_q.y), H_RES)) +
                       ADDR_WIDTH'(cmd_q.x);
          pix_addr_d = row_base_d;
          col_d      = '0;
          row_d      = '0;
          pix_data_d = cmd_q.color;
          state_d    = ST_FILL;
        end
      end
      ST_FILL: begin
        if (last_pix) begin
          // Hold the address on the final pixel so it never leaves the frame.
          state_d = ST_DONE;
        end else if (row_end) begin
          col_d      = '0;
          row_d      = row_q + 9'd1;
          row_base_d = row_base_q + PITCH;
          pix_addr_d = row_base_q + PITCH;
        end else begin
          col_d      = col_q + 10'd1;
          pix_addr_d = pix_addr_q + ADDR_WIDTH'(1);
        end
      end
      ST_DONE: begin
        state_d = ST_IDLE;
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase

    // Status outputs decoded from the next state so they register in step.
    cmd_ready_d = (state_d == ST_IDLE);
    busy_d      = (state_d != ST_IDLE);
    done_d      = (state_d == ST_DONE);
    pix_wen_d   = (state_d == ST_FILL);
  end

  // State and output registers.
  always_ff @(posedge clock or negedge CPU_RESETN) begin
    if (!CPU_RESETN) begin
      state_q     <= ST_IDLE;
      cmd_q       <= '0;
      cw_q        <= '0;
      ch_q        <= '0;
      col_q       <= '0;
      row_q       <= '0;
      row_base_q  <= '0;
      pix_addr_q  <= '0;
      pix_data_q  <= 1'b0;
      pix_wen_q   <= 1'b0;
      busy_q      <= 1'b0;
      done_q      <= 1'b0;
      cmd_ready_q <= 1'b1;
    end else begin
      state_q     <= state_d;
      cmd_q       <= cmd_d;
      cw_q        <= cw_d;
      ch_q        <= ch_d;
      col_q       <= col_d;
      row_q       <= row_d;
      row_base_q  <= row_base_d;
      pix_addr_q  <= pix_addr_d;
      pix_data_q  <= pix_data_d;
      pix_wen_q   <= pix_wen_d;
      busy_q      <= busy_d;
      done_q      <= done_d;
      cmd_ready_q <= cmd_ready_d;
    end
  end

  assign bus.cmd_ready = cmd_ready_q;
  assign bus.pix_addr  = pix_addr_q;
  assign bus.pix_data  = pix_data_q;
  assign bus.pix_wEn   = pix_wen_q;
  assign bus.busy      = busy_q;
  assign bus.done      = done_q;

endmodule

// File: doc/pixel_fill_writer.md
# pixel_fill_writer

Rectangle-fill engine that writes the 1-bit 640x480 pixel framebuffer RAM while the VGA controller reads it. It accepts a fill command (origin, size, colour) over a valid/ready handshake and issues one pixel write per clock to the pixel RAM's write port. The command source is the processor's I/O path. Address arithmetic is incremental and uses no multiplier.

## Interface
- `H_RES`, default 640: visible columns; also the row pitch in the pixel RAM.
- `V_RES`, default 480: visible rows.
- `ADDR_WIDTH`, default 19: pixel RAM address width.

Ports:
- `clock` in 1: single clock shared with the pixel RAM.
- `CPU_RESETN` in 1: asynchronous, active-low reset.
- `cmd_valid` in 1: command present.
- `cmd_ready` out 1: engine idle; accepts a command.
- `cmd_x` in 10: origin column.
- `cmd_y` in 9: origin row.
- `cmd_w` in 10: width in pixels.
- `cmd_h` in 9: height in pixels.
- `cmd_color` in 1: fill value.
- `pix_addr` out ADDR_WIDTH: pixel RAM write address, equal to row*H_RES+col.
- `pix_data` out 1: pixel RAM write data.
- `pix_wEn` out 1: pixel RAM write enable.
- `busy` out 1: high in every state except IDLE.
- `done` out 1: one-cycle pulse when a command completes.

## Operation
- FSM states: IDLE, CLIP, FILL, DONE.
- IDLE:
  - `cmd_ready`=1.
  - On `cmd_valid&&cmd_ready`, register x, y, w, h and colour, then go to CLIP.
- CLIP, one cycle:
  - If x>=H_RES, y>=V_RES, w==0 or h==0: the rectangle is empty; go to DONE.
  - Otherwise set cw=min(w, H_RES-x) and ch=min(h, V_RES-y).
  - Compute row_base = (y<<9)+(y<<7)+x for H_RES=640; the general form is y*H_RES via shift-add.
  - Load `pix_addr`=row_base and col/row counters = 0, then go to FILL.
- FILL:
  - `pix_wEn`=1 and `pix_data`=colour every cycle.
  - Each cycle, col increments and `pix_addr` increments.
  - When col==cw-1: col=0, row++, row_base+=H_RES, `pix_addr`=row_base+H_RES.
  - When col==cw-1 and row==ch-1, go to DONE.
- DONE, one cycle: `done`=1, then go to IDLE.
- Width rules:
  - Sums x+w and y+h are evaluated at 11/10 bits so they cannot overflow.
  - `pix_addr` never exceeds H_RES*V_RES-1.
- `cmd_*` inputs are ignored whenever `cmd_ready`=0; there is no queueing.
- Reset values: state IDLE, `pix_wEn`=0, `pix_addr`=0, `pix_data`=0, `busy`=0, `done`=0, `cmd_ready`=1 after reset release.
- Reset mid-FILL aborts the fill immediately and asynchronously; the pixels already written stay written.

## Timing
- Handshake:
  - Accept on edge E0.
  - CLIP occupies cycle E0..E1.
  - The first write is presented in cycle E1..E2.
- Writes: exactly cw*ch consecutive `pix_wEn` cycles, with no bubbles at row ends.
- Completion: `done` is high in the cycle after the last write; `cmd_ready` returns in the following cycle.
- Total latency:
  - Non-empty fill: accept to `done` = 2+cw*ch cycles.
  - Empty rectangle: 2 cycles, with zero writes.
- Outputs are registered or state-decoded only; there is no combinational path from `cmd_*` to `pix_*`.

## Structure
- A shared package `vga_pkg` holds H_RES, V_RES, ADDR_WIDTH and the state encoding, for reuse by the VGA controller.
- Optional sub-module `fill_addr_gen`: the col/row counters plus the row_base/`pix_addr` incrementer.
- In the FPGA wrapper, the pixel RAM's `wEn`/`addr`/`dataIn` are driven by this block; the read address mux is unchanged.

## Test plan
- x=0, y=0, w=4, h=2, colour=1:
  - Exactly 8 writes at addresses 0,1,2,3,640,641,642,643 with data 1.
  - `done` 10 cycles after accept.
- x=638, y=479, w=10, h=10:
  - Clipped to 2x1: writes at addresses 307198 and 307199.
  - `done` at accept+4.
- w=0, and separately x=700:
  - No `pix_wEn`.
  - `done` at accept+2; `cmd_ready` high at accept+3.
- While `busy`, assert `cmd_valid` with a new command:
  - The new command is ignored.
  - The write count matches the first command only.
- Assert `CPU_RESETN`=0 mid-FILL:
  - `pix_wEn`, `busy` and `done` drop to 0 asynchronously.
  - After release, `cmd_ready`=1 and a new 1x1 fill at (5,5) writes address 3205.
- Full screen, 640x480:
  - 307200 writes, last address 307199.
  - `done` at accept+307202.
